// File: rtl/nes_clock_sequencer.sv
// Master-clock sequencer: PLL lock filter, timed core reset, phase-aligned PPU/CPU enables, pause/ack handshake.
// Define PAL_TIMING_EN for the 80-phase PAL timing (7-bit phase port); default is 12-phase NTSC.
module nes_clock_sequencer #(
  parameter int unsigned LOCK_FILTER = 16,
  parameter int unsigned RESET_HOLD  = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock21,
  input  logic             reset,
  input  logic             clock_locked,
  input  logic             pause_req,
  output logic             pause_ack,
  output logic             sys_reset,
  output logic             ppu_ce,
  output logic             cpu_ce,
`ifdef PAL_TIMING_EN
  output logic [6:0]       phase,
`else
  output logic [3:0]       phase,
`endif
  output logic [CNT_W-1:0] cpu_cycle_count
);

`ifdef PAL_TIMING_EN
  localparam int unsigned PHASE_W = 7;
  localparam int unsigned PERIOD  = 80;
`else
  localparam int unsigned PHASE_W = 4;
  localparam int unsigned PERIOD  = 12;
`endif
  localparam int unsigned LOCK_W = $clog2(LOCK_FILTER + 1);
  localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 1);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PERIOD - 1);
  localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_FILTER - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2,
    PAUSED    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               ppu_hit;
  logic               cpu_hit;
  logic               enables_on;
  logic [PHASE_W-1:0] phase_next;

`ifdef PAL_TIMING_EN
  assign ppu_hit = (phase_q % 7'd5) == 7'd0;
  assign cpu_hit = phase_q[3:0] == 4'd0;
`else
  assign ppu_hit = phase_q[1:0] == 2'b00;
  assign cpu_hit = phase_q == 4'd0;
`endif

  // Outputs are pure decodes of registered state; no input reaches an output combinationally.
  assign enables_on      = (state_q == HOLD) || (state_q == RUN);
  assign ppu_ce          = enables_on && ppu_hit;
  assign cpu_ce          = enables_on && cpu_hit;
  assign sys_reset       = (state_q == WAIT_LOCK) || (state_q == HOLD);
  assign pause_ack       = (state_q == PAUSED);
  assign phase           = phase_q;
  assign cpu_cycle_count = count_q;

  assign phase_next = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    lock_cnt_d = lock_cnt_q;
    hold_cnt_d = hold_cnt_q;
    count_d    = count_q;

    case (state_q)
      WAIT_LOCK: begin
        phase_d = '0;
        if (clock_locked) begin
          if (lock_cnt_q == LOCK_LAST) begin
            state_d    = HOLD;
            lock_cnt_d = '0;
            hold_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end else begin
          lock_cnt_d = '0;
        end
      end
      HOLD: begin
        phase_d = phase_next;
        if (hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + 1'b1;
        if ((hold_cnt_q == HOLD_LAST) && (phase_q == PHASE_LAST)) state_d = RUN;
      end
      RUN: begin
        phase_d = phase_next;
        if (cpu_hit) count_d = count_q + 1'b1;
        if (pause_req && (phase_q == PHASE_LAST)) state_d = PAUSED;
      end
      PAUSED: begin
        phase_d = '0;
        if (!pause_req) state_d = RUN;
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Lock loss overrides every transition above and restores the power-up values.
    if ((state_q != WAIT_LOCK) && !clock_locked) begin
      state_d    = WAIT_LOCK;
      phase_d    = '0;
      lock_cnt_d = '0;
      hold_cnt_d = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clock21) begin
    if (reset) begin
      state_q    <= WAIT_LOCK;
      phase_q    <= '0;
      lock_cnt_q <= '0;
      hold_cnt_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      lock_cnt_q <= lock_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_nes_clock_sequencer.sv
// Directed bench for nes_clock_sequencer (LOCK_FILTER=4, RESET_HOLD=8, CNT_W=4); PAL_TIMING_EN selects the PAL scenario.
module tb_nes_clock_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       clock_locked;
  logic       pause_req;
  logic       pause_ack;
  logic       sys_reset;
  logic       ppu_ce;
  logic       cpu_ce;
`ifdef PAL_TIMING_EN
  logic [6:0] phase;
`else
  logic [3:0] phase;
`endif
  logic [3:0] cpu_cycle_count;

  int n_cmp = 0;
  int n_bad = 0;

  nes_clock_sequencer #(
    .LOCK_FILTER(4),
    .RESET_HOLD (8),
    .CNT_W      (4)
  ) dut (
    .clock21        (clk),
    .reset          (reset),
    .clock_locked   (clock_locked),
    .pause_req      (pause_req),
    .pause_ack      (pause_ack),
    .sys_reset      (sys_reset),
    .ppu_ce         (ppu_ce),
    .cpu_ce         (cpu_ce),
    .phase          (phase),
    .cpu_cycle_count(cpu_cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {sys_reset, ppu_ce, cpu_ce, pause_ack}
  function automatic logic [3:0] flags();
    return {sys_reset, ppu_ce, cpu_ce, pause_ack};
  endfunction

  task automatic test_reset();
    reset = 1'b1; clock_locked = 1'b0; pause_req = 1'b0;
    tick(); tick();
    n_cmp++; if (flags() !== 4'b1000) begin n_bad++; $display("FAIL reset_flags got %b want %b", flags(), 4'b1000); end
    n_cmp++; if (phase !== '0) begin n_bad++; $display("FAIL reset_phase got %0d want 0", phase); end
    n_cmp++; if (cpu_cycle_count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", cpu_cycle_count); end
  endtask

`ifndef PAL_TIMING_EN
  task automatic test_glitchy_lock();
    logic       pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp_f;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      clock_locked = pat[k];
      tick();
      exp_f = (k == 7) ? 4'b1110 : 4'b1000;
      n_cmp++; if (flags() !== exp_f) begin n_bad++; $display("FAIL glitch_flags[%0d] got %b want %b", k, flags(), exp_f); end
      n_cmp++; if (phase !== 4'd0) begin n_bad++; $display("FAIL glitch_phase[%0d] got %0d want 0", k, phase); end
    end
  endtask

  task automatic test_power_up();
    reset = 1'b1; clock_locked = 1'b0; pause_req = 1'b0;
    tick(); tick();
    reset = 1'b0; clock_locked = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++; if (flags() !== 4'b1000) begin n_bad++; $display("FAIL pu_wait[%0d] got %b want %b", k, flags(), 4'b1000); end
    end
    tick();
    n_cmp++; if (flags() !== 4'b1110) begin n_bad++; $display("FAIL pu_hold_entry got %b want %b", flags(), 4'b1110); end
    for (int p = 1; p <= 11; p++) begin
      tick();
      n_cmp++; if (phase !== 4'(p)) begin n_bad++; $display("FAIL pu_hold_phase got %0d want %0d", phase, p); end
      n_cmp++; if (flags() !== {1'b1, (p % 4) == 0, 2'b00}) begin n_bad++; $display("FAIL pu_hold_flags[%0d] got %b want %b", p, flags(), {1'b1, (p % 4) == 0, 2'b00}); end
    end
    tick();
    n_cmp++; if (flags() !== 4'b0110) begin n_bad++; $display("FAIL pu_run_entry got %b want %b", flags(), 4'b0110); end
    n_cmp++; if (phase !== 4'd0) begin n_bad++; $display("FAIL pu_run_phase got %0d want 0", phase); end
    n_cmp++; if (cpu_cycle_count !== 4'd0) begin n_bad++; $display("FAIL pu_run_count0 got %0d want 0", cpu_cycle_count); end
    tick();
    n_cmp++; if (cpu_cycle_count !== 4'd1) begin n_bad++; $display("FAIL pu_run_count1 got %0d want 1", cpu_cycle_count); end
    n_cmp++; if (phase !== 4'd1) begin n_bad++; $display("FAIL pu_run_phase1 got %0d want 1", phase); end
  endtask

  task automatic test_enable_pattern();
    int n_ppu = 0;
    int n_cpu = 0;
    repeat (11) tick();
    n_cmp++; if (phase !== 4'd0) begin n_bad++; $display("FAIL en_start_phase got %0d want 0", phase); end
    for (int i = 0; i < 24; i++) begin
      n_cmp++; if (phase !== 4'(i % 12)) begin n_bad++; $display("FAIL en_phase[%0d] got %0d want %0d", i, phase, i % 12); end
      n_cmp++; if ({ppu_ce, cpu_ce} !== {(i % 4) == 0, (i % 12) == 0}) begin n_bad++; $display("FAIL en_ce[%0d] got %b want %b", i, {ppu_ce, cpu_ce}, {(i % 4) == 0, (i % 12) == 0}); end
      n_ppu += int'(ppu_ce);
      n_cpu += int'(cpu_ce);
      tick();
    end
    n_cmp++; if (n_ppu != 6) begin n_bad++; $display("FAIL en_ppu_total got %0d want 6", n_ppu); end
    n_cmp++; if (n_cpu != 2) begin n_bad++; $display("FAIL en_cpu_total got %0d want 2", n_cpu); end
    n_cmp++; if (cpu_cycle_count !== 4'd3) begin n_bad++; $display("FAIL en_count got %0d want 3", cpu_cycle_count); end
  endtask

  task automatic test_pause();
    repeat (3) tick();
    pause_req = 1'b1;
    for (int p = 4; p <= 11; p++) begin
      tick();
      n_cmp++; if (pause_ack !== 1'b0 || phase !== 4'(p)) begin n_bad++; $display("FAIL pz_pending[%0d] got ack=%b phase=%0d want ack=0 phase=%0d", p, pause_ack, phase, p); end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (flags() !== 4'b0001) begin n_bad++; $display("FAIL pz_paused_flags[%0d] got %b want %b", k, flags(), 4'b0001); end
      n_cmp++; if (phase !== 4'd0 || cpu_cycle_count !== 4'd4) begin n_bad++; $display("FAIL pz_paused_state[%0d] got phase=%0d cnt=%0d want 0/4", k, phase, cpu_cycle_count); end
    end
    pause_req = 1'b0;
    tick();
    n_cmp++; if (flags() !== 4'b0110 || phase !== 4'd0) begin n_bad++; $display("FAIL pz_resume got %b phase=%0d want %b phase=0", flags(), phase, 4'b0110); end
    n_cmp++; if (cpu_cycle_count !== 4'd4) begin n_bad++; $display("FAIL pz_resume_count got %0d want 4", cpu_cycle_count); end
    tick();
    n_cmp++; if (cpu_cycle_count !== 4'd5) begin n_bad++; $display("FAIL pz_after_count got %0d want 5", cpu_cycle_count); end
  endtask

  task automatic test_pause_cancel();
    pause_req = 1'b1;
    repeat (4) tick();
    pause_req = 1'b0;
    for (int p = 6; p <= 12; p++) begin
      tick();
      n_cmp++; if (pause_ack !== 1'b0 || phase !== 4'(p % 12)) begin n_bad++; $display("FAIL cancel[%0d] got ack=%b phase=%0d want ack=0 phase=%0d", p, pause_ack, phase, p % 12); end
    end
    n_cmp++; if (cpu_ce !== 1'b1) begin n_bad++; $display("FAIL cancel_cpu_ce got %b want 1", cpu_ce); end
    tick();
    n_cmp++; if (cpu_cycle_count !== 4'd6) begin n_bad++; $display("FAIL cancel_count got %0d want 6", cpu_cycle_count); end
  endtask

  task automatic test_lock_loss_run();
    clock_locked = 1'b0;
    tick();
    n_cmp++; if (flags() !== 4'b1000) begin n_bad++; $display("FAIL llr_flags got %b want %b", flags(), 4'b1000); end
    n_cmp++; if (phase !== 4'd0 || cpu_cycle_count !== 4'd0) begin n_bad++; $display("FAIL llr_state got phase=%0d cnt=%0d want 0/0", phase, cpu_cycle_count); end
    clock_locked = 1'b1;
    repeat (3) tick();
    n_cmp++; if (flags() !== 4'b1000) begin n_bad++; $display("FAIL llr_still_wait got %b want %b", flags(), 4'b1000); end
    tick();
    n_cmp++; if (flags() !== 4'b1110) begin n_bad++; $display("FAIL llr_hold got %b want %b", flags(), 4'b1110); end
    repeat (11) tick();
    n_cmp++; if (sys_reset !== 1'b1 || phase !== 4'd11) begin n_bad++; $display("FAIL llr_hold_end got sr=%b phase=%0d want 1/11", sys_reset, phase); end
    tick();
    n_cmp++; if (flags() !== 4'b0110) begin n_bad++; $display("FAIL llr_run got %b want %b", flags(), 4'b0110); end
  endtask

  task automatic test_lock_loss_paused();
    repeat (11) tick();
    pause_req = 1'b1;
    tick();
    n_cmp++; if (flags() !== 4'b0001 || cpu_cycle_count !== 4'd1) begin n_bad++; $display("FAIL llp_paused got %b cnt=%0d want %b cnt=1", flags(), cpu_cycle_count, 4'b0001); end
    tick();
    clock_locked = 1'b0;
    tick();
    n_cmp++; if (flags() !== 4'b1000 || cpu_cycle_count !== 4'd0) begin n_bad++; $display("FAIL llp_reset got %b cnt=%0d want %b cnt=0", flags(), cpu_cycle_count, 4'b1000); end
    clock_locked = 1'b1;
    repeat (4) tick();
    n_cmp++; if (flags() !== 4'b1110) begin n_bad++; $display("FAIL llp_hold got %b want %b", flags(), 4'b1110); end
    repeat (11) tick();
    n_cmp++; if (pause_ack !== 1'b0 || sys_reset !== 1'b1) begin n_bad++; $display("FAIL llp_hold_end got ack=%b sr=%b want 0/1", pause_ack, sys_reset); end
    tick();
    n_cmp++; if (flags() !== 4'b0110) begin n_bad++; $display("FAIL llp_run got %b want %b", flags(), 4'b0110); end
    repeat (11) tick();
    n_cmp++; if (pause_ack !== 1'b0 || phase !== 4'd11) begin n_bad++; $display("FAIL llp_run_end got ack=%b phase=%0d want 0/11", pause_ack, phase); end
    tick();
    n_cmp++; if (flags() !== 4'b0001) begin n_bad++; $display("FAIL llp_repause got %b want %b", flags(), 4'b0001); end
    pause_req = 1'b0;
    tick();
    n_cmp++; if (flags() !== 4'b0110 || cpu_cycle_count !== 4'd1) begin n_bad++; $display("FAIL llp_resume got %b cnt=%0d want %b cnt=1", flags(), cpu_cycle_count, 4'b0110); end
  endtask

  task automatic test_count_wrap();
    repeat (180) tick();
    n_cmp++; if (cpu_cycle_count !== 4'd0 || phase !== 4'd0) begin n_bad++; $display("FAIL wrap_zero got cnt=%0d phase=%0d want 0/0", cpu_cycle_count, phase); end
    repeat (12) tick();
    n_cmp++; if (cpu_cycle_count !== 4'd1) begin n_bad++; $display("FAIL wrap_one got %0d want 1", cpu_cycle_count); end
  endtask
`else
  task automatic test_pal();
    int n_ppu = 0;
    int n_cpu = 0;
    reset = 1'b0; clock_locked = 1'b1;
    repeat (4) tick();
    n_cmp++; if (flags() !== 4'b1110) begin n_bad++; $display("FAIL pal_hold got %b want %b", flags(), 4'b1110); end
    repeat (79) tick();
    n_cmp++; if (sys_reset !== 1'b1 || phase !== 7'd79) begin n_bad++; $display("FAIL pal_hold_end got sr=%b phase=%0d want 1/79", sys_reset, phase); end
    tick();
    n_cmp++; if (flags() !== 4'b0110 || phase !== 7'd0) begin n_bad++; $display("FAIL pal_run got %b phase=%0d want %b/0", flags(), phase, 4'b0110); end
    for (int i = 0; i < 80; i++) begin
      n_cmp++; if ({ppu_ce, cpu_ce, pause_ack} !== {(i % 5) == 0, (i % 16) == 0, 1'b0}) begin n_bad++; $display("FAIL pal_ce[%0d] got %b want %b", i, {ppu_ce, cpu_ce, pause_ack}, {(i % 5) == 0, (i % 16) == 0, 1'b0}); end
      n_ppu += int'(ppu_ce);
      n_cpu += int'(cpu_ce);
      if (i == 10) pause_req = 1'b1;
      tick();
    end
    n_cmp++; if (n_ppu != 16 || n_cpu != 5) begin n_bad++; $display("FAIL pal_totals got ppu=%0d cpu=%0d want 16/5", n_ppu, n_cpu); end
    n_cmp++; if (flags() !== 4'b0001 || phase !== 7'd0) begin n_bad++; $display("FAIL pal_paused got %b phase=%0d want %b/0", flags(), phase, 4'b0001); end
    n_cmp++; if (cpu_cycle_count !== 4'd5) begin n_bad++; $display("FAIL pal_count got %0d want 5", cpu_cycle_count); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef PAL_TIMING_EN
    test_glitchy_lock();
    test_power_up();
    test_enable_pattern();
    test_pause();
    test_pause_cancel();
    test_lock_loss_run();
    test_lock_loss_paused();
    test_count_wrap();
`else
    test_pal();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nes_clock_sequencer.md
Name: nes_clock_sequencer

Overview:
Sequences the master clock domain after the PLL wrapper has locked. It filters `clock_locked` and holds system reset for a programmable time. It then generates the phase-aligned PPU and CPU clock enables from the ~21.477 MHz master clock. It also offers a pause/ack handshake that halts the enables on a CPU-cycle boundary. It sits directly after the clock/PLL wrapper and feeds every enable-gated block in the NES core.

Parameters:
- LOCK_FILTER, 16: consecutive cycles `clock_locked` must be high before leaving WAIT_LOCK (≥1).
- RESET_HOLD, 1024: minimum cycles `sys_reset` stays high after lock is qualified (≥1).
- CNT_W, 16: width of `cpu_cycle_count`.

Ports:
- clock21  in  1  master clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- clock_locked  in  1  PLL lock, already synchronised to clock21.
- pause_req  in  1  request to halt the enables at a CPU-cycle boundary.
- pause_ack  out  1  high while halted.
- sys_reset  out  1  synchronous active-high reset for the core.
- ppu_ce  out  1  PPU dot clock enable, one-cycle pulse.
- cpu_ce  out  1  CPU clock enable, one-cycle pulse.
- phase  out  4  current master-cycle phase, 0..PERIOD-1 (7 bits with PAL_TIMING_EN).
- cpu_cycle_count  out  CNT_W  count of cpu_ce pulses since sys_reset fell.

Behaviour:
- Interface: one clock, `clock21`. `reset` is synchronous and active-high.
- All state is registered. Outputs decode registered state only; there is no combinational path from any input to any output.
- Reset values: state=WAIT_LOCK, sys_reset=1, ppu_ce=0, cpu_ce=0, pause_ack=0, phase=0, cpu_cycle_count=0, lock_cnt=0, hold_cnt=0.
- NTSC timing: PERIOD=12.
  - ppu_ce=1 when phase ∈ {0,4,8}.
  - cpu_ce=1 when phase==0.
  - Enables are gated by state, as listed below.
- State WAIT_LOCK:
  - sys_reset=1, enables 0, phase held 0.
  - lock_cnt increments while clock_locked=1 and clears to 0 whenever clock_locked=0.
  - When lock_cnt==LOCK_FILTER-1 and clock_locked=1, go to HOLD with hold_cnt=0.
- State HOLD:
  - sys_reset=1.
  - phase runs (wraps PERIOD-1→0) and enables pulse normally, so enable-gated reset logic downstream executes.
  - hold_cnt increments, saturating at RESET_HOLD-1.
  - When hold_cnt==RESET_HOLD-1 and phase==PERIOD-1, go to RUN. The first RUN cycle therefore has phase=0 and cpu_ce=1.
- State RUN:
  - sys_reset=0, phase wraps, enables pulse.
  - cpu_cycle_count increments on every cpu_ce and wraps at 2^CNT_W.
  - If pause_req=1 in a cycle with phase==PERIOD-1, go to PAUSED. Otherwise stay in RUN.
- State PAUSED:
  - phase=0, ppu_ce=cpu_ce=0, pause_ack=1, sys_reset=0, cpu_cycle_count held.
  - When pause_req=0, return to RUN. The next cycle has phase=0, cpu_ce=1 and pause_ack=0.
- Lock loss: clock_locked=0 in HOLD, RUN or PAUSED sends the block to WAIT_LOCK on the next edge, with full reset values.
  - lock_cnt restarts.
  - Lock loss has priority over pause and hold transitions.
- pause_req raised while in WAIT_LOCK or HOLD has no effect. It is honoured at the first RUN boundary where it is still high.
- pause_req dropped before the boundary cancels the pause; no ack is produced.
- Priority when events coincide: reset > lock loss > state transition.

Optional Feature:
- Macro: PAL_TIMING_EN.
- Defined:
  - PERIOD=80.
  - ppu_ce when phase%5==0 (16 pulses per period).
  - cpu_ce when phase%16==0 (5 pulses per period).
  - phase port is 7 bits.
  - The pause boundary is phase==79, so PAUSED is entered only at a point where both enables are phase-coherent.
  - The HOLD→RUN exit also waits for phase==79.
- Undefined: NTSC behaviour as above; phase port is 4 bits.

Test Plan:
All tests use LOCK_FILTER=4 and RESET_HOLD=8.
- Power-up lock: reset 2 cycles, then clock_locked=1 → HOLD entered 4 cycles after lock rises. sys_reset falls exactly on the first phase==0 after hold_cnt reaches 7. That cycle has cpu_ce=1 and cpu_cycle_count becomes 1 on the following cycle.
- Glitchy lock: clock_locked pattern 1,1,1,0,1,1,1,1 → only the second run of four qualifies. sys_reset stays 1 throughout the glitch.
- Enable pattern in RUN over 24 cycles:
  - ppu_ce high at phases 0,4,8, i.e. 6 pulses.
  - cpu_ce high at phase 0, i.e. 2 pulses.
  - cpu_cycle_count +2.
- Pause: pause_req=1 at phase 3 → RUN continues to phase 11, then pause_ack=1 with phase=0 and no enables while paused. Drop pause_req → next cycle phase=0, cpu_ce=1, pause_ack=0, count resumes without loss.
- Lock loss in RUN and PAUSED: clock_locked=0 for 1 cycle → next cycle sys_reset=1, enables 0, pause_ack=0, count=0. Re-qualification requires 4 more locked cycles plus 8 hold cycles.
- PAL_TIMING_EN build: 80 RUN cycles → 16 ppu_ce pulses, 5 cpu_ce pulses. A pause is entered only after phase 79.
